i2c_txn_scheduler: RTL and testbench

- Shares the single APB-to-I2C master command port (wren/rden/addr/wdata/ce in; rdata/error out) among NUM_REQ on-chip requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Watchdog timeout if the I2C master never signals completion.
- Sits between requesting agents and the I2C master's APB-facing modport, inside the I2C subsystem top.

---
 rtl/i2c_txn_scheduler_pkg.sv | 25 ++
 rtl/i2c_txn_scheduler_rr_pick.sv | 39 +++
 rtl/i2c_txn_scheduler.sv | 162 ++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_txn_scheduler_pkg.sv
// Shared types for the I2C transaction scheduler: FSM states, the latched
// command record and a helper for requester-index widths.
package i2c_sched_pkg;

   localparam int DEF_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
   } sched_cmd_t;

   // A single requester still needs a 1-bit index so ports never collapse.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_txn_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// otherwise the lowest set request.
module i2c_rr_pick
   import i2c_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IW-1:0]      win_idx,
   output logic               any
);

   logic found;

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= int'(rr_ptr))) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         win_onehot[i] = found && (win_idx == IW'(i));
      end
      any = |req;
   end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one I2C master command port among NUM_REQ
// requesters, one transaction in flight, with a watchdog on completion.
module i2c_txn_scheduler
   import i2c_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_wr,
   input  logic [8*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [7:0]           rsp_rdata,
   output logic                 rsp_error,
   output logic                 busy,
   output logic                 timeout_evt,
   output logic                 m_ce,
   output logic                 m_wren,
   output logic                 m_rden,
   output logic [7:0]           m_addr,
   output logic [7:0]           m_wdata,
   input  logic [7:0]           m_rdata,
   input  logic                 m_error,
   input  logic                 m_done
);

   localparam int IW = ptr_w(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT);

   // Handshake: a requester holds req with its operands stable until gnt
   // pulses; gnt means the command is latched and committed, and exactly one
   // rsp_valid pulse to that requester follows (unless reset intervenes).
   sched_state_t         state, state_d;
   sched_cmd_t           cmd, cmd_d, win_cmd;
   logic [IW-1:0]        owner, owner_d, rr_ptr, rr_ptr_d, win_idx;
   logic [TW-1:0]        timer, timer_d;
   logic [NUM_REQ-1:0]   win_onehot, owner_oh;
   logic [NUM_REQ-1:0]   gnt_d, rsp_valid_d;
   logic [7:0]           rsp_rdata_d;
   logic                 rsp_error_d, busy_d, timeout_d;
   logic                 m_ce_d, m_wren_d, m_rden_d, any;

   i2c_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any        (any)
   );

   assign m_addr  = cmd.addr;
   assign m_wdata = cmd.wdata;

   always_comb begin
      win_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) begin
            win_cmd.wr    = req_wr[i];
            win_cmd.addr  = req_addr[8*i +: 8];
            win_cmd.wdata = req_wdata[8*i +: 8];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_oh[i] = (owner == IW'(i));
      end
   end

   always_comb begin
      state_d     = state;
      cmd_d       = cmd;
      owner_d     = owner;
      rr_ptr_d    = rr_ptr;
      timer_d     = timer;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata;
      rsp_error_d = rsp_error;
      timeout_d   = 1'b0;
      m_ce_d      = 1'b0;
      m_wren_d    = 1'b0;
      m_rden_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any) begin
               cmd_d    = win_cmd;
               owner_d  = win_idx;
               gnt_d    = win_onehot;
               m_ce_d   = 1'b1;
               m_wren_d = win_cmd.wr;
               m_rden_d = ~win_cmd.wr;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A real completion beats a watchdog expiring in the same cycle.
            if (m_done) begin
               rsp_rdata_d = cmd.wr ? 8'h00 : m_rdata;
               rsp_error_d = m_error;
               rsp_valid_d = owner_oh;
               state_d     = ST_RESP;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               rsp_rdata_d = 8'h00;
               rsp_error_d = 1'b1;
               timeout_d   = 1'b1;
               rsp_valid_d = owner_oh;
               state_d     = ST_RESP;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         ST_RESP: begin
            rr_ptr_d = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cmd         <= '0;
         owner       <= '0;
         rr_ptr      <= '0;
         timer       <= '0;
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_error   <= 1'b0;
         busy        <= 1'b0;
         timeout_evt <= 1'b0;
         m_ce        <= 1'b0;
         m_wren      <= 1'b0;
         m_rden      <= 1'b0;
      end else begin
         state       <= state_d;
         cmd         <= cmd_d;
         owner       <= owner_d;
         rr_ptr      <= rr_ptr_d;
         timer       <= timer_d;
         gnt         <= gnt_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_error   <= rsp_error_d;
         busy        <= busy_d;
         timeout_evt <= timeout_d;
         m_ce        <= m_ce_d;
         m_wren      <= m_wren_d;
         m_rden      <= m_rden_d;
      end
   end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler (NUM_REQ=4, TIMEOUT=8): vector table of
// single transactions plus hand-written fairness, watchdog and reset sequences.
module tb_i2c_txn_scheduler;

   localparam int N  = 4;
   localparam int W  = 9;

   typedef struct {
      int         idx;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         dly;
      logic [7:0] m_rd;
      logic       m_err;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, req_wr, gnt, rsp_valid;
   logic [8*N-1:0] req_addr, req_wdata;
   logic [7:0]     rsp_rdata, m_addr, m_wdata, m_rdata;
   logic           rsp_error, busy, timeout_evt, m_ce, m_wren, m_rden;
   logic           m_error, m_done;

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [W-1:0]   exp_q[$];
   logic [W-1:0]   exp_rsp;
   int             gnt_q[$];
   int             exp_owner;
   vec_t           vecs[4];
   vec_t           v;

   i2c_txn_scheduler #(.NUM_REQ(N), .TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_error   (rsp_error),
      .busy        (busy),
      .timeout_evt (timeout_evt),
      .m_ce        (m_ce),
      .m_wren      (m_wren),
      .m_rden      (m_rden),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_error     (m_error),
      .m_done      (m_done)
   );

   // Clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   task automatic drive_req(input int idx, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata);
      req[idx]              = 1'b1;
      req_wr[idx]           = wr;
      req_addr[8*idx +: 8]  = addr;
      req_wdata[8*idx +: 8] = wdata;
   endtask

   task automatic master_done(input logic [7:0] rd, input logic err);
      m_done  = 1'b1;
      m_rdata = rd;
      m_error = err;
   endtask

   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      while (gnt == '0 && n < 16) begin
         tick();
         n++;
      end
      check({name, "_gnt_seen"}, 32'(gnt != '0), 32'd1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rsp"}, {gnt, rsp_valid, rsp_rdata, rsp_error, busy, timeout_evt}, 32'd0);
      check({name, "_mst"}, {m_ce, m_wren, m_rden, m_addr, m_wdata}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      m_rdata = '0; m_error = 1'b0; m_done = 1'b0;

      //          idx wr  addr   wdata  dly m_rd   m_err exp_rd exp_err
      vecs[0] = '{2, 1'b0, 8'h3C, 8'h00, 2, 8'hA5, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{1, 1'b1, 8'h10, 8'h5A, 1, 8'h77, 1'b1, 8'h00, 1'b1};
      vecs[2] = '{3, 1'b0, 8'h7F, 8'h00, 3, 8'hC3, 1'b1, 8'hC3, 1'b1};
      vecs[3] = '{0, 1'b1, 8'hFF, 8'h01, 1, 8'hFF, 1'b0, 8'h00, 1'b0};

      // Reset state
      tick(); tick(); tick();
      check_all_zero("reset_hold");
      reset = 1'b0;
      tick();
      check_all_zero("reset_idle");

      // Single transactions from the vector table
      for (int k = 0; k < 4; k++) begin
         v = vecs[k];
         exp_q.push_back({v.exp_err, v.exp_rd});
         drive_req(v.idx, v.wr, v.addr, v.wdata);
         wait_gnt("vec");
         check("vec_gnt", 32'(gnt), 32'(oh(v.idx)));
         check("vec_issue_strobes", {m_ce, m_wren, m_rden}, {1'b1, v.wr, ~v.wr});
         check("vec_issue_addr", {m_addr, m_wdata}, {v.addr, v.wdata});
         req = '0;
         for (int d = 1; d <= v.dly; d++) begin
            tick();
            check("vec_wait", {m_ce, m_wren, m_rden, busy, m_addr, rsp_valid},
                  {3'b000, 1'b1, v.addr, 4'b0000});
            if (d == v.dly) master_done(v.m_rd, v.m_err);
         end
         tick();
         m_done = 1'b0;
         check("vec_rsp_valid", 32'(rsp_valid), 32'(oh(v.idx)));
         exp_rsp = exp_q.pop_front();
         check("vec_rsp_data", {rsp_error, rsp_rdata}, exp_rsp);
         tick();
         check("vec_idle", {busy, rsp_valid, gnt}, 9'd0);
      end

      // Fairness: all requesters held, done in the first WAIT cycle
      do_reset();
      gnt_q = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) drive_req(i, 1'b0, 8'(8'h20 + i), 8'h00);
      wait_gnt("fair");
      for (int t = 0; t < 5; t++) begin
         exp_owner = gnt_q.pop_front();
         check("fair_gnt", 32'(gnt), 32'(oh(exp_owner)));
         check("fair_onehot", $countones(gnt), 1);
         check("fair_issue", {m_ce, m_rden, m_addr}, {1'b1, 1'b1, 8'(8'h20 + exp_owner)});
         if (t == 4) req = '0;
         tick();
         master_done(8'(8'h10 + t), 1'b0);
         tick();
         m_done = 1'b0;
         check("fair_rsp", {rsp_valid, rsp_rdata}, {oh(exp_owner), 8'(8'h10 + t)});
         tick();
         check("fair_idle", {busy, gnt}, 5'd0);
         if (t < 4) tick();
      end

      // Watchdog: no done for 8 WAIT cycles
      drive_req(1, 1'b0, 8'h55, 8'h00);
      wait_gnt("to");
      check("to_gnt", 32'(gnt), 32'(oh(1)));
      req = '0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check("to_wait", {timeout_evt, rsp_valid, busy}, 6'b0_0000_1);
      end
      tick();
      check("to_fire", {timeout_evt, rsp_valid, rsp_error, rsp_rdata, busy},
            {1'b1, oh(1), 1'b1, 8'h00, 1'b1});
      tick();
      check("to_after", {timeout_evt, rsp_valid, busy}, 6'd0);

      // Done on the same cycle the watchdog would fire
      drive_req(1, 1'b0, 8'h56, 8'h00);
      wait_gnt("tie");
      req = '0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 8) master_done(8'h3C, 1'b0);
      end
      tick();
      m_done = 1'b0;
      check("tie_rsp", {timeout_evt, rsp_valid, rsp_error, rsp_rdata},
            {1'b0, oh(1), 1'b0, 8'h3C});
      tick();
      check("tie_idle", 32'(busy), 32'd0);

      // Reset during WAIT abandons the command; pointer returns to 0
      drive_req(3, 1'b0, 8'h44, 8'h00);
      wait_gnt("rst");
      req = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      master_done(8'h99, 1'b0);
      check_all_zero("rst_mid_wait");
      tick();
      m_done = 1'b0;
      check("rst_no_rsp", {rsp_valid, busy}, 5'd0);
      drive_req(3, 1'b0, 8'h61, 8'h00);
      drive_req(1, 1'b0, 8'h62, 8'h00);
      wait_gnt("rst_arb");
      check("rst_arb_gnt", {gnt, m_addr}, {oh(1), 8'h62});
      req = '0;
      tick();
      master_done(8'h61, 1'b0);
      tick();
      m_done = 1'b0;
      check("rst_arb_rsp", {rsp_valid, rsp_rdata}, {oh(1), 8'h61});
      tick();

      // Spurious done in IDLE and ISSUE
      master_done(8'hEE, 1'b1);
      tick();
      m_done = 1'b0;
      check("spur_idle", {busy, rsp_valid, rsp_error, rsp_rdata}, {1'b0, 4'b0000, 1'b0, 8'h61});
      tick();
      drive_req(0, 1'b0, 8'h70, 8'h00);
      wait_gnt("spur");
      req = '0;
      master_done(8'hEE, 1'b1);
      tick();
      m_done = 1'b0;
      check("spur_issue", {busy, rsp_valid}, 5'b1_0000);
      tick();
      check("spur_wait", {busy, rsp_valid}, 5'b1_0000);
      master_done(8'h42, 1'b0);
      tick();
      m_done = 1'b0;
      check("spur_rsp", {rsp_valid, rsp_error, rsp_rdata}, {oh(0), 1'b0, 8'h42});
      tick();
      check("spur_end", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global guard so a stuck run still reports
   initial begin
      #200000;
      $display("FAIL global_timeout: got hang, expected finish");
      $fatal(1, "timeout");
   end

endmodule
